// File: rtl/div_pkg.sv
// Shared constants and types for the divider issue front-end.
// The tracker entry records which in-flight chain slot carries a live operation.
package div_pkg;

    localparam int DIV_DATA_WIDTH = 16;
    localparam int DIV_TAG_WIDTH  = 4;

    localparam logic [DIV_DATA_WIDTH-1:0] ALL_ONES = '1;

    typedef struct packed {
        logic                     valid;
        logic [DIV_TAG_WIDTH-1:0] tag;
        logic                     dbz;
    } trk_entry_t;

endpackage

// File: rtl/div_req_fifo.sv
// Synchronous circular-buffer FIFO with registered count.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module div_req_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/div_issue.sv
// Issue front-end for the pipelined divider chain: buffers requests, feeds the
// chain head once per cycle, and pairs tail quotients with tags via a tracker.
module div_issue
    import div_pkg::*;
#(
    parameter int DATA_WIDTH    = DIV_DATA_WIDTH,
    parameter int FIFO_DEPTH    = 4,
    parameter int TAG_WIDTH     = DIV_TAG_WIDTH,
    parameter int CHAIN_LATENCY = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic [DATA_WIDTH-1:0] A_out,
    output logic [DATA_WIDTH-1:0] B_out,
    output logic [DATA_WIDTH-1:0] C_out,
    output logic [DATA_WIDTH-1:0] Max_out,
    output logic [DATA_WIDTH-1:0] Min_out,
    output logic                  issue_valid,
    input  logic [DATA_WIDTH-1:0] res_c,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_q,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic                  rsp_dbz,
    output logic                  busy
);
    localparam int EW = 2 * DATA_WIDTH + TAG_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  ready_q;
    logic                  push, pop;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [EW-1:0]         head;
    logic [DATA_WIDTH-1:0] head_a, head_b;
    logic [TAG_WIDTH-1:0]  head_tag;

    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, max_q, max_d;
    logic                  iv_q, iv_d, idbz_q, idbz_d;
    logic [TAG_WIDTH-1:0]  itag_q, itag_d;

    trk_entry_t            trk_q [CHAIN_LATENCY];
    trk_entry_t            trk_d [CHAIN_LATENCY];
    trk_entry_t            tail;
    logic                  trk_any;

    logic                  rv_q, rv_d, rd_q, rd_d;
    logic [DATA_WIDTH-1:0] rq_q, rq_d;
    logic [TAG_WIDTH-1:0]  rt_q, rt_d;

    // ready_q keeps req_ready low while reset is held.
    assign req_ready = ready_q && !fifo_full;
    assign push      = req_valid && req_ready;
    assign pop       = !fifo_empty;

    div_req_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({req_a, req_b, req_tag}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_a   = head[EW-1 -: DATA_WIDTH];
    assign head_b   = head[TAG_WIDTH +: DATA_WIDTH];
    assign head_tag = head[TAG_WIDTH-1:0];

    always_comb begin
        a_d    = '0;
        b_d    = '0;
        max_d  = '0;
        iv_d   = 1'b0;
        itag_d = '0;
        if (pop) begin
            a_d    = head_a;
            b_d    = head_b;
            max_d  = ALL_ONES;
            iv_d   = 1'b1;
            itag_d = head_tag;
        end
        idbz_d = (b_d == '0);
    end

    // Slot 0 takes the operation visible at the chain head, so the tail slot
    // lines up with the cycle its quotient appears on res_c.
    always_comb begin
        trk_d[0].valid = iv_q;
        trk_d[0].tag   = itag_q;
        trk_d[0].dbz   = idbz_q;
        for (int i = 1; i < CHAIN_LATENCY; i++) trk_d[i] = trk_q[i-1];
    end

    always_comb begin
        trk_any = 1'b0;
        for (int i = 0; i < CHAIN_LATENCY; i++) trk_any = trk_any | trk_q[i].valid;
    end

    assign tail = trk_q[CHAIN_LATENCY-1];

    always_comb begin
        rv_d = tail.valid;
        rq_d = rq_q;
        rt_d = rt_q;
        rd_d = rd_q;
        if (tail.valid) begin
            rt_d = tail.tag;
            rd_d = tail.dbz;
            rq_d = tail.dbz ? ALL_ONES : res_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            max_q   <= '0;
            iv_q    <= 1'b0;
            itag_q  <= '0;
            idbz_q  <= 1'b0;
            for (int i = 0; i < CHAIN_LATENCY; i++) trk_q[i] <= '0;
            rv_q    <= 1'b0;
            rq_q    <= '0;
            rt_q    <= '0;
            rd_q    <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            a_q     <= a_d;
            b_q     <= b_d;
            max_q   <= max_d;
            iv_q    <= iv_d;
            itag_q  <= itag_d;
            idbz_q  <= idbz_d;
            trk_q   <= trk_d;
            rv_q    <= rv_d;
            rq_q    <= rq_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

    assign A_out       = a_q;
    assign B_out       = b_q;
    assign C_out       = '0;
    assign Max_out     = max_q;
    assign Min_out     = '0;
    assign issue_valid = iv_q;
    assign rsp_valid   = rv_q;
    assign rsp_q       = rq_q;
    assign rsp_tag     = rt_q;
    assign rsp_dbz     = rd_q;
    assign busy        = (fifo_count != '0) || iv_q || trk_any || rv_q;

endmodule

// File: doc/div_issue.md
# div_issue

Request front-end for the divider stage chain. Accepts divide requests through a valid/ready handshake and buffers them in a small FIFO. Issues one operation per cycle into the head of the fully pipelined divider chain as initial (A, B, C, Max, Min) operands. Tracks each in-flight operation with a latency-matched shift register and emits a tagged response, with divide-by-zero override, when the chain tail produces the quotient.

## Interface
- DATA_WIDTH, 16, operand/quotient width
- FIFO_DEPTH, 4, request buffer entries (power of two, ≥2)
- TAG_WIDTH, 4, request tag width
- CHAIN_LATENCY, 32, cycles from issue to quotient valid at chain tail (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  FIFO can accept
- req_a  in  DATA_WIDTH  dividend
- req_b  in  DATA_WIDTH  divisor
- req_tag  in  TAG_WIDTH  caller tag
- A_out  out  DATA_WIDTH  chain initial dividend
- B_out  out  DATA_WIDTH  chain initial divisor
- C_out  out  DATA_WIDTH  chain initial quotient
- Max_out  out  DATA_WIDTH  chain initial upper search bound
- Min_out  out  DATA_WIDTH  chain initial lower search bound
- issue_valid  out  1  issue registers hold a live operation
- res_c  in  DATA_WIDTH  quotient from chain tail
- rsp_valid  out  1  one-cycle response strobe
- rsp_q  out  DATA_WIDTH  quotient
- rsp_tag  out  TAG_WIDTH  tag of the response
- rsp_dbz  out  1  divide-by-zero flag
- busy  out  1  FIFO non-empty, issue live, or any tracker slot valid

## Operation
- Accept: handshake when req_valid && req_ready. req_ready = (count < FIFO_DEPTH), registered-count based, no same-cycle pop pass-through. A full FIFO stalls even if popping that cycle.
- FIFO entry: {a, b, tag}. Circular read/write pointers wrap modulo FIFO_DEPTH. Count is updated for push, pop, and simultaneous push+pop (unchanged).
- Issue: every cycle the FIFO is non-empty, pop the head. The chain never back-pressures.
  - On a pop, load A_out=a, B_out=b, C_out=0, Max_out=all ones, Min_out=0, issue_valid=1.
  - With no pop, load all issue operand outputs with 0 and issue_valid=0. A bubble has B=0, so the chain yields 0, which the tracker ignores.
- Tracker: a CHAIN_LATENCY-deep shift register of {valid, tag, dbz}. It is loaded with {issue_valid, tag, b==0} in lockstep with the issue registers and advances every cycle.
- Response: when the tail slot is valid, at the next edge load rsp_valid=1, rsp_tag=tail tag, rsp_dbz=tail dbz, and rsp_q = dbz ? all ones : res_c. Otherwise rsp_valid=0, and rsp_q/rsp_tag/rsp_dbz hold their last values.
- Responses have no back-pressure. The consumer must take rsp on its strobe. Responses return in issue order.
- Reset: all outputs 0 (req_ready=0 during reset, 1 in the first cycle after). FIFO emptied, all tracker valids cleared. Reset mid-operation discards all buffered and in-flight requests, and no response is produced for them.

## Timing
- Request accepted at edge t into an empty FIFO → issue_valid high in the cycle after edge t+1.
- Issue in cycle k → res_c sampled in cycle k+CHAIN_LATENCY → rsp_valid high in cycle k+CHAIN_LATENCY+1.
- Total request-to-response latency is CHAIN_LATENCY+2 cycles when no queueing occurs.
- Sustained throughput is one request per cycle (FIFO push and pop in the same cycle).
- busy falls in the cycle after the last rsp_valid.

## Structure
- Shared package div_pkg: DATA_WIDTH/TAG_WIDTH defaults, the all-ones constant, and the tracker entry struct {valid, tag, dbz}.
- One sub-module: div_req_fifo (parameterised sync FIFO with push/pop/full/empty/count).
- The tracker shift register and the issue registers live in div_issue.

## Test plan
Bench uses a chain stub: a CHAIN_LATENCY-cycle delay of a/b (0 if b=0), with CHAIN_LATENCY=4.
- Single request a=100, b=7, tag=3 → issue A_out=100, B_out=7, Max_out=0xFFFF, Min_out=0; rsp_valid in cycle k+5 with rsp_q=14, rsp_tag=3, rsp_dbz=0.
- a=5, b=0, tag=9 → rsp_q=0xFFFF, rsp_dbz=1, rsp_tag=9.
- Back-to-back requests every cycle, with tags 0..7 and {1000/10, 255/16, 7/9, 65535/1, …} → eight consecutive responses, in order, with correct quotients (100, 15, 0, 65535, …); req_ready stays 1.
- Chain-stall emulation: hold issue by forcing 5 pushes while the FIFO is prevented from draining via a bench-only force on the pop path → req_ready=0 after 4 accepted; the fifth is accepted only after a pop. No request is lost or duplicated.
- Assert rst for one cycle with 2 buffered and 3 in-flight requests → no rsp_valid afterwards, busy=0 and req_ready=1 the next cycle, and a subsequent request a=9, b=3 returns rsp_q=3.
